seg7_scan_driver: RTL

//  Multiplexed N-digit 7-segment display driver; generalises the single-segment
//  seg_a decode to all segments a..g, hex or BCD mode, and time-multiplexed digits.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 25 ++
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Segment bit positions, hex glyph table and blank pattern
//               shared by the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Entry n is the gfedcba pattern for nibble n; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    function automatic logic [6:0] seg_hex_pattern(input logic [3:0] nibble);
        return SEG_HEX_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational nibble to active-high gfedcba segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = seg_hex_pattern(i_nibble);
        // BCD mode has no glyphs for 10..15, so those codes go dark.
        if (i_blank || (!i_hex_mode && (i_nibble > 4'd9))) begin
            o_seg = SEG_BLANK;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit 7-segment driver with double-buffered
//               display value, blanking, leading-zero suppression and dp.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int HEX_MODE    = 1,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending
);

    localparam int c_pre_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_an_inv   = {DIGITS{AN_ACT_LOW != 0}};
    localparam logic [6:0]         c_seg_inv  = {7{SEG_ACT_LOW != 0}};

    logic [c_pre_w-1:0]  r_presc;
    logic [c_idx_w-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_shadow_value, r_disp_value;
    logic [DIGITS-1:0]   r_shadow_dp, r_disp_dp;
    logic [DIGITS-1:0]   r_shadow_blank, r_disp_blank;
    logic                r_pending;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_tick, w_frame_wrap;
    logic [DIGITS-1:0]   w_zero_from;
    logic                w_zero_run;
    logic [3:0]          w_nibble;
    logic                w_dp_bit, w_blank_bit, w_zero_sel, w_lz_blank;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_an_onehot;

    assign w_tick       = (r_presc == c_pre_last);
    assign w_frame_wrap = w_tick && (r_idx == c_idx_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_pre_w'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            end
        end
    end

    // The displayed copy only moves at a frame boundary so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '0;
            r_disp_value   <= '0;
            r_disp_dp      <= '0;
            r_disp_blank   <= '0;
            r_pending      <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_value <= value;
                r_shadow_dp    <= dp_in;
                r_shadow_blank <= blank_in;
            end
            if (w_frame_wrap) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp_value <= value;
                    r_disp_dp    <= dp_in;
                    r_disp_blank <= blank_in;
                end else if (r_pending) begin
                    r_disp_value <= r_shadow_value;
                    r_disp_dp    <= r_shadow_dp;
                    r_disp_blank <= r_shadow_blank;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // w_zero_from[i]: nibbles i..DIGITS-1 of the displayed value are all zero.
    always_comb begin
        w_zero_run  = 1'b1;
        w_zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run     = w_zero_run && (r_disp_value[4*i +: 4] == 4'd0);
            w_zero_from[i] = w_zero_run;
        end
    end

    always_comb begin
        w_nibble    = '0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_zero_sel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nibble    = r_disp_value[4*i +: 4];
                w_dp_bit    = r_disp_dp[i];
                w_blank_bit = r_disp_blank[i];
                w_zero_sel  = w_zero_from[i];
            end
        end
    end

    assign w_lz_blank  = lz_en && (r_idx != '0) && w_zero_sel;
    assign w_an_onehot = DIGITS'(1) << r_idx;

    seg7_decode u_decode (
        .i_nibble   (w_nibble),
        .i_hex_mode (HEX_MODE != 0),
        .i_blank    (w_blank_bit || w_lz_blank),
        .o_seg      (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= c_an_inv;
            r_seg <= c_seg_inv;
            r_dp  <= c_seg_inv[0];
        end else begin
            r_an  <= w_an_onehot ^ c_an_inv;
            r_seg <= w_seg ^ c_seg_inv;
            r_dp  <= w_dp_bit ^ c_seg_inv[0];
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign pending = r_pending;

endmodule
`default_nettype wire
